// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the CPU instruction-fetch port
// (read-only) and the CPU data port (load/store). Data requests have fixed
// priority over fetches. An anti-starvation streak counter caps how many data
// grants can be made in a row while a fetch is waiting. A watchdog ends an
// access with an error response if the memory never acknowledges it.
//
// Transaction shape: IDLE (grant edge) -> BUSY (>=1 cycle, mem_req=1)
//                    -> RESP (1 cycle, requester ack) -> IDLE.
// No new grant is made while in BUSY or RESP.
//
// Ports
//   clk, reset            clock; synchronous active-low reset (0 = reset)
//   i_req/i_addr          fetch request, held until i_ack
//   i_ack/i_err/i_rdata   fetch completion pulse, timeout flag and data
//   d_req/d_we/d_addr/
//   d_wdata/d_mask        data request, held until d_ack
//   d_ack/d_err/d_rdata   data completion pulse, timeout flag, load data
//   mem_req/mem_we/
//   mem_addr/mem_wdata/
//   mem_mask              registered memory request and fields
//   mem_ack/mem_rdata     memory completion and read data (used only in BUSY)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic            i_err,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_mask,
  output logic            d_ack,
  output logic            d_err,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_mask,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  // Streak counter only needs to reach MAX_STREAK.
  localparam int            SW         = (MAX_STREAK > 1) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_CAP = SW'(MAX_STREAK);

  // Watchdog counts completed BUSY cycles; expiry is at TIMEOUT-1.
  localparam int            WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit            WDOG_EN   = (TIMEOUT != 0);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t          state_r;
  state_t          state_s;
  owner_t          owner_r;
  owner_t          owner_s;
  logic [SW-1:0]   streak_r;
  logic [SW-1:0]   streak_s;
  logic [WW-1:0]   wdog_r;
  logic [WW-1:0]   wdog_s;

  logic            mem_req_s;
  logic            mem_we_s;
  logic [XLEN-1:0] mem_addr_s;
  logic [XLEN-1:0] mem_wdata_s;
  logic [3:0]      mem_mask_s;
  logic            i_ack_s;
  logic            i_err_s;
  logic [XLEN-1:0] i_rdata_s;
  logic            d_ack_s;
  logic            d_err_s;
  logic [XLEN-1:0] d_rdata_s;

  logic            grant_data_s;
  logic            resp_fire_s;
  logic            resp_err_s;
  logic [XLEN-1:0] resp_data_s;

  // Data wins unless a fetch is waiting and data has used up its streak.
  assign grant_data_s = d_req & (~i_req | (streak_r < STREAK_CAP));

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    streak_s    = streak_r;
    wdog_s      = wdog_r;
    mem_req_s   = 1'b0;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    mem_mask_s  = mem_mask;
    i_ack_s     = 1'b0;
    i_err_s     = i_err;
    i_rdata_s   = i_rdata;
    d_ack_s     = 1'b0;
    d_err_s     = d_err;
    d_rdata_s   = d_rdata;
    resp_fire_s = 1'b0;
    resp_err_s  = 1'b0;
    resp_data_s = {XLEN{1'b0}};

    case (state_r)
      IDLE: begin
        if (grant_data_s) begin
          state_s     = BUSY;
          owner_s     = OWN_DATA;
          mem_req_s   = 1'b1;
          mem_we_s    = d_we;
          mem_addr_s  = d_addr;
          mem_wdata_s = d_wdata;
          mem_mask_s  = d_mask;
          wdog_s      = {WW{1'b0}};
          // Only data grants that bypass a waiting fetch lengthen the streak.
          if (i_req) begin
            streak_s = (streak_r == STREAK_CAP) ? STREAK_CAP : (streak_r + SW'(1));
          end else begin
            streak_s = {SW{1'b0}};
          end
        end else if (i_req) begin
          state_s     = BUSY;
          owner_s     = OWN_FETCH;
          mem_req_s   = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = i_addr;
          mem_wdata_s = {XLEN{1'b0}};
          mem_mask_s  = 4'b0000;
          wdog_s      = {WW{1'b0}};
          streak_s    = {SW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end

      BUSY: begin
        mem_req_s = 1'b1;
        // A real acknowledge takes precedence over watchdog expiry.
        if (mem_ack) begin
          state_s     = RESP;
          mem_req_s   = 1'b0;
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b0;
          if ((owner_r == OWN_DATA) && mem_we) begin
            resp_data_s = {XLEN{1'b0}};
          end else begin
            resp_data_s = mem_rdata;
          end
        end else if (WDOG_EN && (wdog_r == WDOG_LAST)) begin
          state_s     = RESP;
          mem_req_s   = 1'b0;
          resp_fire_s = 1'b1;
          resp_err_s  = 1'b1;
          resp_data_s = {XLEN{1'b0}};
        end else begin
          wdog_s = wdog_r + WW'(1);
        end
      end

      RESP: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase

    // Route the completion to whichever port owns the transaction.
    if (resp_fire_s) begin
      if (owner_r == OWN_DATA) begin
        d_ack_s   = 1'b1;
        d_err_s   = resp_err_s;
        d_rdata_s = resp_data_s;
      end else begin
        i_ack_s   = 1'b1;
        i_err_s   = resp_err_s;
        i_rdata_s = resp_data_s;
      end
    end else begin
      d_ack_s = 1'b0;
      i_ack_s = 1'b0;
    end
  end

  // State and registered-output update; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      owner_r   <= OWN_FETCH;
      streak_r  <= {SW{1'b0}};
      wdog_r    <= {WW{1'b0}};
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {XLEN{1'b0}};
      mem_wdata <= {XLEN{1'b0}};
      mem_mask  <= 4'b0000;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= {XLEN{1'b0}};
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= {XLEN{1'b0}};
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      streak_r  <= streak_s;
      wdog_r    <= wdog_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
      mem_mask  <= mem_mask_s;
      i_ack     <= i_ack_s;
      i_err     <= i_err_s;
      i_rdata   <= i_rdata_s;
      d_ack     <= d_ack_s;
      d_err     <= d_err_s;
      d_rdata   <= d_rdata_s;
    end
  end

endmodule
